// File: rtl/wm8731_pkg.sv
// Shared types, widths and register reset defaults for the WM8731 control-port responder.
package wm8731_pkg;

    localparam int REG_AW = 7;
    localparam int REG_DW = 9;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        ACK_A,
        BYTE1,
        ACK_1,
        BYTE2,
        ACK_2,
        IGNORE
    } wm_state_t;

    typedef struct packed {
        logic [REG_AW-1:0] addr;
        logic [REG_DW-1:0] data;
    } wm_wr_t;

    // Codec power-on values for R0..R9; anything beyond reads back as zero.
    function automatic logic [REG_DW-1:0] reg_default(input int idx);
        case (idx)
            0:       return 9'h097;
            1:       return 9'h097;
            2:       return 9'h079;
            3:       return 9'h079;
            4:       return 9'h00A;
            5:       return 9'h008;
            6:       return 9'h09F;
            7:       return 9'h00A;
            default: return 9'h000;
        endcase
    endfunction

    function automatic logic maj3(input logic [2:0] s);
        return (s[0] & s[1]) | (s[0] & s[2]) | (s[1] & s[2]);
    endfunction

endpackage

// File: rtl/i2c_line_cond.sv
// SCL/SDA conditioning: 2-FF synchronisers, optional majority filter (WM_GLITCH_FILTER_EN),
// SCL edge detection and START/STOP recognition on the cleaned lines.
module i2c_line_cond
    import wm8731_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic scl_async,
    input  logic sda_async,
    output logic sda,
    output logic scl_rise,
    output logic scl_fall,
    output logic start,
    output logic stop
);

    logic [1:0] scl_sync, sda_sync;
    logic       scl_c, sda_c, scl_d, sda_d;

    // Idle bus level is high, so the pipeline resets to 1 to avoid phantom edges.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_sync <= 2'b11;
            sda_sync <= 2'b11;
        end else begin
            scl_sync <= {scl_sync[0], scl_async};
            sda_sync <= {sda_sync[0], sda_async};
        end
    end

`ifdef WM_GLITCH_FILTER_EN
    logic [2:0] scl_hist, sda_hist;
    logic       scl_f, sda_f;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_hist <= 3'b111;
            sda_hist <= 3'b111;
            scl_f    <= 1'b1;
            sda_f    <= 1'b1;
        end else begin
            scl_hist <= {scl_hist[1:0], scl_sync[1]};
            sda_hist <= {sda_hist[1:0], sda_sync[1]};
            scl_f    <= maj3(scl_hist);
            sda_f    <= maj3(sda_hist);
        end
    end

    assign scl_c = scl_f;
    assign sda_c = sda_f;
`else
    assign scl_c = scl_sync[1];
    assign sda_c = sda_sync[1];
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_d <= 1'b1;
            sda_d <= 1'b1;
        end else begin
            scl_d <= scl_c;
            sda_d <= sda_c;
        end
    end

    assign sda      = sda_c;
    assign scl_rise = scl_c & ~scl_d;
    assign scl_fall = ~scl_c & scl_d;
    assign start    = scl_c & scl_d & sda_d & ~sda_c;
    assign stop     = scl_c & scl_d & ~sda_d & sda_c;

endmodule

// File: rtl/wm8731_i2c_responder.sv
// WM8731 control-port I2C target: ACKs 3-byte write frames and keeps a readable shadow
// register file. Build with WM_GLITCH_FILTER_EN to add majority filtering on SCL/SDA.
module wm8731_i2c_responder
    import wm8731_pkg::*;
#(
    parameter logic [6:0] DEV_ADDR  = 7'h1A,
    parameter int         NUM_REGS  = 10,
    parameter logic [6:0] RESET_REG = 7'h0F
) (
    input  logic        CLOCK_50,
    input  logic        RESET_N,
    input  logic        I2C_SCLK,
    input  logic        I2C_SDAT_IN,
    output logic        I2C_SDAT_OE,
    output logic        wr_valid,
    output logic [6:0]  wr_addr,
    output logic [8:0]  wr_data,
    input  logic [3:0]  rd_addr,
    output logic [8:0]  rd_data,
    output logic        busy
);

    logic sda, scl_rise, scl_fall, start, stop;

    i2c_line_cond u_line_cond (
        .clk       (CLOCK_50),
        .rst_n     (RESET_N),
        .scl_async (I2C_SCLK),
        .sda_async (I2C_SDAT_IN),
        .sda       (sda),
        .scl_rise  (scl_rise),
        .scl_fall  (scl_fall),
        .start     (start),
        .stop      (stop)
    );

    wm_state_t   state, state_nx;
    logic [2:0]  cnt, cnt_nx;
    logic [7:0]  shreg, shreg_nx, b1, b1_nx;
    logic        byte_done, byte_done_nx;
    logic        oe, oe_nx, busy_q, busy_nx;
    logic        commit;
    wm_wr_t      wr_q;

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            state     <= IDLE;
            cnt       <= '0;
            shreg     <= '0;
            b1        <= '0;
            byte_done <= 1'b0;
            oe        <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            shreg     <= shreg_nx;
            b1        <= b1_nx;
            byte_done <= byte_done_nx;
            oe        <= oe_nx;
            busy_q    <= busy_nx;
        end
    end

    // Bits are shifted on SCL rise; every decision and OE change waits for the SCL fall.
    always_comb begin
        state_nx     = state;
        cnt_nx       = cnt;
        shreg_nx     = shreg;
        b1_nx        = b1;
        byte_done_nx = byte_done;
        oe_nx        = oe;
        busy_nx      = busy_q;
        commit       = 1'b0;
        if (start) begin
            state_nx     = ADDR;
            cnt_nx       = '0;
            byte_done_nx = 1'b0;
            oe_nx        = 1'b0;
            busy_nx      = 1'b1;
        end else if (stop) begin
            state_nx     = IDLE;
            byte_done_nx = 1'b0;
            oe_nx        = 1'b0;
            busy_nx      = 1'b0;
        end else if (state == ADDR || state == BYTE1 || state == BYTE2) begin
            if (scl_rise && !byte_done) begin
                shreg_nx = {shreg[6:0], sda};
                cnt_nx   = cnt + 3'd1;
                if (cnt == 3'd7)
                    byte_done_nx = 1'b1;
            end else if (scl_fall && byte_done) begin
                byte_done_nx = 1'b0;
                if (state == ADDR) begin
                    if (shreg[7:1] == DEV_ADDR && !shreg[0]) begin
                        state_nx = ACK_A;
                        oe_nx    = 1'b1;
                    end else begin
                        state_nx = IGNORE;
                    end
                end else if (state == BYTE1) begin
                    b1_nx    = shreg;
                    state_nx = ACK_1;
                    oe_nx    = 1'b1;
                end else begin
                    state_nx = ACK_2;
                    oe_nx    = 1'b1;
                    commit   = 1'b1;
                end
            end
        end else if (scl_fall) begin
            case (state)
                ACK_A:   begin state_nx = BYTE1;  oe_nx = 1'b0; cnt_nx = '0; end
                ACK_1:   begin state_nx = BYTE2;  oe_nx = 1'b0; cnt_nx = '0; end
                ACK_2:   begin state_nx = IGNORE; oe_nx = 1'b0; end
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            wr_valid <= 1'b0;
            wr_q     <= '0;
        end else begin
            wr_valid <= commit;
            if (commit)
                wr_q <= '{addr: b1[7:1], data: {b1[0], shreg}};
        end
    end

    assign wr_addr     = wr_q.addr;
    assign wr_data     = wr_q.data;
    assign I2C_SDAT_OE = oe;
    assign busy        = busy_q;

    logic [REG_DW-1:0] regs [NUM_REGS];
    logic [REG_DW-1:0] rd_mux;

    // Registers update the cycle wr_valid is high; the soft-reset address wins over a store.
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            for (int i = 0; i < NUM_REGS; i++)
                regs[i] <= reg_default(i);
        end else if (wr_valid && wr_addr == RESET_REG) begin
            for (int i = 0; i < NUM_REGS; i++)
                regs[i] <= reg_default(i);
        end else if (wr_valid) begin
            for (int i = 0; i < NUM_REGS; i++)
                if (int'(wr_addr) == i)
                    regs[i] <= wr_data;
        end
    end

    always_comb begin
        rd_mux = '0;
        for (int i = 0; i < NUM_REGS; i++)
            if (int'(rd_addr) == i)
                rd_mux = regs[i];
    end

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N)
            rd_data <= '0;
        else
            rd_data <= rd_mux;
    end

endmodule
